// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters and the RAM.
// slave: arbiter side. master: the fetch stage / loader / RAM environment side.
interface imem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12
);
  // fetch stage
  logic              in_fetch_req;
  logic [31:0]       in_fetch_addr;
  logic              fetch_gnt_out;
  logic              fetch_valid_out;
  logic [31:0]       fetch_data_out;
  logic              stall_out;
  // program loader
  logic              in_load_req;
  logic [31:0]       in_load_addr;
  logic [31:0]       in_load_data;
  logic              load_gnt_out;
  // instruction RAM
  logic              mem_en_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [31:0]       mem_wdata_out;
  logic [31:0]       in_mem_rdata;

  modport slave (
    input  in_fetch_req, in_fetch_addr, in_load_req, in_load_addr, in_load_data,
           in_mem_rdata,
    output fetch_gnt_out, fetch_valid_out, fetch_data_out, stall_out, load_gnt_out,
           mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out
  );

  modport master (
    output in_fetch_req, in_fetch_addr, in_load_req, in_load_addr, in_load_data,
           in_mem_rdata,
    input  fetch_gnt_out, fetch_valid_out, fetch_data_out, stall_out, load_gnt_out,
           mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Single-port instruction memory arbiter: fetch (read) has priority, the loader
// (write) is forced through after MAX_WAIT consecutive denied cycles.
// Optional: define IMEM_ARB_PERF_EN to add fetch-grant and stall-cycle counters.
// Grants, stall and memory controls are combinational; read data is returned
// in the cycle after a fetch grant, straight from the registered RAM.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  imem_port_arbiter_if.slave      bus
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]             perf_fetch_cnt_out,
  output logic [31:0]             perf_stall_cnt_out
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              load_force;
  logic              fetch_gnt;
  logic              load_gnt;
  logic              stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] fetch_word;
  logic [ADDR_W-1:0] load_word;
  logic              rd_pending;

  // Byte offset and bits above the memory size are intentionally dropped.
  assign fetch_word = bus.in_fetch_addr[ADDR_W+1:2];
  assign load_word  = bus.in_load_addr[ADDR_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.in_fetch_addr[31:ADDR_W+2], bus.in_fetch_addr[1:0],
                              bus.in_load_addr[31:ADDR_W+2], bus.in_load_addr[1:0]};

  // FETCH state means the previous cycle issued a read: RAM data is on in_mem_rdata now.
  assign rd_pending = (state_q == S_FETCH);

  // State, starvation counter and held read word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      data_q     <= data_d;
    end
  end

  // Arbitration, memory controls, next state and starvation counter update.
  always_comb begin
    load_force = 1'b0;
    fetch_gnt  = 1'b0;
    load_gnt   = 1'b0;
    stall      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    state_d    = S_IDLE;
    wait_cnt_d = '0;
    data_d     = rd_pending ? bus.in_mem_rdata : data_q;

    // Nothing is granted while reset is held, so the RAM is never touched.
    if (rst_n) begin
      load_force = bus.in_load_req && (wait_cnt_q == CNT_W'(MAX_WAIT));
      if (load_force) begin
        load_gnt = 1'b1;
      end else if (bus.in_fetch_req) begin
        fetch_gnt = 1'b1;
      end else if (bus.in_load_req) begin
        load_gnt = 1'b1;
      end

      if (fetch_gnt) begin
        mem_en   = 1'b1;
        mem_addr = fetch_word;
        state_d  = S_FETCH;
      end else if (load_gnt) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = load_word;
        mem_wdata = bus.in_load_data;
        state_d   = S_LOAD;
      end

      stall = bus.in_fetch_req && !fetch_gnt;

      if (bus.in_load_req && !load_gnt) begin
        wait_cnt_d = (wait_cnt_q == CNT_W'(MAX_WAIT)) ? wait_cnt_q
                                                      : wait_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.fetch_gnt_out   = fetch_gnt;
  assign bus.load_gnt_out    = load_gnt;
  assign bus.stall_out       = stall;
  assign bus.mem_en_out      = mem_en;
  assign bus.mem_we_out      = mem_we;
  assign bus.mem_addr_out    = mem_addr;
  assign bus.mem_wdata_out   = mem_wdata;
  assign bus.fetch_valid_out = rd_pending;
  assign bus.fetch_data_out  = rd_pending ? bus.in_mem_rdata : data_q;

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  // Free-running wrap-around counters of fetch grants and stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fetch_gnt) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (stall)     perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_out = perf_fetch_q;
  assign perf_stall_cnt_out = perf_stall_q;
`endif

endmodule
